// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the VeriRISC fetch side: opcodes, phase names and
// the run/halt sequencer states. The controller imports the same package.
package fetch_sequencer_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    // DRAIN is RUN with a halt pending: the instruction finishes, then HALTED.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STEP   = 2'd1,
        HALTED = 2'd2,
        DRAIN  = 2'd3
    } seq_state_t;

    function automatic logic is_active(seq_state_t s);
        return s != HALTED;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its controller/debug host.
// master drives strobes and memory data; slave is the sequencer itself.
interface fetch_sequencer_if #(
    parameter int AWIDTH = 5,
    parameter int OPW    = 3
);
    localparam int DWIDTH = OPW + AWIDTH;

    logic [DWIDTH-1:0] data_in;
    logic              ld_ir;
    logic              inc_pc;
    logic              ld_pc;
    logic              halt;
    logic              go;
    logic              step;

    logic [2:0]        phase;
    logic [OPW-1:0]    opcode;
    logic [AWIDTH-1:0] ir_addr;
    logic [AWIDTH-1:0] pc_addr;
    logic              running;
    logic              instr_done;

    modport master (
        output data_in, ld_ir, inc_pc, ld_pc, halt, go, step,
        input  phase, opcode, ir_addr, pc_addr, running, instr_done
    );

    modport slave (
        input  data_in, ld_ir, inc_pc, ld_pc, halt, go, step,
        output phase, opcode, ir_addr, pc_addr, running, instr_done
    );

endinterface

// File: rtl/fetch_sequencer_phase_counter.sv
// 3-bit instruction phase counter with enable and a registered pulse
// marking the cycle in which the count has just wrapped 7->0.
module phase_counter
    import fetch_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       en,
    output logic [2:0] count,
    output logic       wrap
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= 3'd0;
            wrap  <= 1'b0;
        end else begin
            wrap <= en && (count == PH_STORE);
            if (en) begin
                count <= count + 3'd1;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// VeriRISC fetch sequencer: phase generation, IR and PC, plus a
// run/halt/single-step state machine for debug control.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int AWIDTH    = 5,
    parameter int OPW       = 3,
    parameter int DWIDTH    = 8,
    parameter bit START_RUN = 1'b1
) (
    input logic              clk,
    input logic              rst_,
    fetch_sequencer_if.slave bus
);

    if (DWIDTH != OPW + AWIDTH) begin : g_width_check
        $error("fetch_sequencer: DWIDTH must equal OPW + AWIDTH");
    end

    seq_state_t        state;
    logic              running;
    logic              active;
    logic [2:0]        phase;
    logic              wrap;
    logic [DWIDTH-1:0] ir;
    logic [AWIDTH-1:0] pc;

    assign active = is_active(state);

    phase_counter u_phase (
        .clk   (clk),
        .clr_n (rst_),
        .en    (active),
        .count (phase),
        .wrap  (wrap)
    );

    // Halting and stepping only ever leave the active states on the 7->0 wrap.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= START_RUN ? RUN : HALTED;
            running <= START_RUN;
        end else begin
            case (state)
                HALTED: begin
                    if (bus.go) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (bus.step) begin
                        state   <= STEP;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.halt) begin
                        if (phase == PH_STORE) begin
                            state   <= HALTED;
                            running <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                STEP, DRAIN: begin
                    if (phase == PH_STORE) begin
                        state   <= HALTED;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= HALTED;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // ld_pc uses the operand already in IR, so a same-cycle ld_ir does not feed it.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ir <= {OPW'(OP_HLT), {AWIDTH{1'b0}}};
            pc <= '0;
        end else if (active) begin
            if (bus.ld_ir) begin
                ir <= bus.data_in;
            end
            if (bus.ld_pc) begin
                pc <= ir[AWIDTH-1:0];
            end else if (bus.inc_pc) begin
                pc <= pc + AWIDTH'(1);
            end
        end
    end

    assign bus.phase      = phase;
    assign bus.opcode     = ir[DWIDTH-1:AWIDTH];
    assign bus.ir_addr    = ir[AWIDTH-1:0];
    assign bus.pc_addr    = pc;
    assign bus.running    = running;
    assign bus.instr_done = wrap;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table, directed halt/step/
// reset sequences and random strobes against a behavioural model.
module tb_fetch_sequencer;

    typedef struct {
        logic [7:0] data;
        logic       ld_ir;
        logic       inc_pc;
        logic       ld_pc;
        logic       halt;
        logic       go;
        logic       step;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [17:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.AWIDTH(5), .OPW(3)) bus ();
    fetch_sequencer_if #(.AWIDTH(5), .OPW(3)) bus2 ();

    fetch_sequencer #(.AWIDTH(5), .OPW(3), .DWIDTH(8), .START_RUN(1'b1)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    fetch_sequencer #(.AWIDTH(5), .OPW(3), .DWIDTH(8), .START_RUN(1'b0)) dut_halted (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus2)
    );

    // Reference model: one instruction is eight phases; a halted machine sits at phase 0.
    int m_phase, m_ir, m_pc;
    bit m_halted, m_pending, m_stepping, m_done;

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            m_phase    <= 0;
            m_ir       <= 0;
            m_pc       <= 0;
            m_halted   <= 1'b0;
            m_pending  <= 1'b0;
            m_stepping <= 1'b0;
            m_done     <= 1'b0;
        end else if (m_halted) begin
            m_done <= 1'b0;
            if (bus.go) begin
                m_halted   <= 1'b0;
                m_stepping <= 1'b0;
            end else if (bus.step) begin
                m_halted   <= 1'b0;
                m_stepping <= 1'b1;
            end
        end else begin
            m_done <= (m_phase == 7);
            if (bus.ld_pc)       m_pc <= m_ir % 32;
            else if (bus.inc_pc) m_pc <= (m_pc + 1) % 32;
            if (bus.ld_ir)       m_ir <= int'(bus.data_in);
            if (m_phase == 7) begin
                m_phase <= 0;
                if (m_pending || m_stepping || bus.halt) begin
                    m_halted   <= 1'b1;
                    m_pending  <= 1'b0;
                    m_stepping <= 1'b0;
                end
            end else begin
                m_phase <= m_phase + 1;
                if (bus.halt) m_pending <= 1'b1;
            end
        end
    end

    function automatic logic [17:0] ow(input int ph, input int op, input int ira,
                                       input int pc, input int run, input int done);
        return {3'(ph), 3'(op), 5'(ira), 5'(pc), 1'(run), 1'(done)};
    endfunction

    function automatic stim_t mk(input int data, input int ld_ir, input int inc_pc, input int ld_pc);
        stim_t s;
        s.data   = 8'(data);
        s.ld_ir  = 1'(ld_ir);
        s.inc_pc = 1'(inc_pc);
        s.ld_pc  = 1'(ld_pc);
        s.halt   = 1'b0;
        s.go     = 1'b0;
        s.step   = 1'b0;
        return s;
    endfunction

    function automatic logic [17:0] dut_word();
        return {bus.phase, bus.opcode, bus.ir_addr, bus.pc_addr, bus.running, bus.instr_done};
    endfunction

    function automatic logic [17:0] dut2_word();
        return {bus2.phase, bus2.opcode, bus2.ir_addr, bus2.pc_addr, bus2.running, bus2.instr_done};
    endfunction

    function automatic logic [17:0] model_word();
        return ow(m_phase, m_ir / 32, m_ir % 32, m_pc, m_halted ? 0 : 1, m_done ? 1 : 0);
    endfunction

    task automatic applyStimulus(input stim_t s);
        bus.data_in = s.data;
        bus.ld_ir   = s.ld_ir;
        bus.inc_pc  = s.inc_pc;
        bus.ld_pc   = s.ld_pc;
        bus.halt    = s.halt;
        bus.go      = s.go;
        bus.step    = s.step;
    endtask

    task automatic checkOutput(input string name, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got ph=%0d op=%0d ir=%0d pc=%0d run=%0b done=%0b, expected ph=%0d op=%0d ir=%0d pc=%0d run=%0b done=%0b",
                     name, got[17:15], got[14:12], got[11:7], got[6:2], got[1], got[0],
                     exp[17:15], exp[14:12], exp[11:7], exp[6:2], exp[1], exp[0]);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t  vecs[16];
        stim_t s;
        int    cyc, dones;
        bit    ended, stayed, found;

        // Instruction LDA 3 then PC wrap / ld_pc priority, from a fresh reset in RUN.
        vecs[0]  = '{mk(8'h00, 0, 0, 0), ow(1, 0, 0, 0, 1, 0)};
        vecs[1]  = '{mk(8'hA3, 1, 0, 0), ow(2, 5, 3, 0, 1, 0)};
        vecs[2]  = '{mk(8'h00, 0, 1, 0), ow(3, 5, 3, 1, 1, 0)};
        vecs[3]  = '{mk(8'h00, 0, 0, 0), ow(4, 5, 3, 1, 1, 0)};
        vecs[4]  = '{mk(8'h00, 0, 0, 0), ow(5, 5, 3, 1, 1, 0)};
        vecs[5]  = '{mk(8'h00, 0, 0, 0), ow(6, 5, 3, 1, 1, 0)};
        vecs[6]  = '{mk(8'h00, 0, 0, 0), ow(7, 5, 3, 1, 1, 0)};
        vecs[7]  = '{mk(8'h00, 0, 0, 0), ow(0, 5, 3, 1, 1, 1)};
        vecs[8]  = '{mk(8'hFF, 1, 0, 0), ow(1, 7, 31, 1, 1, 0)};
        vecs[9]  = '{mk(8'h00, 0, 0, 1), ow(2, 7, 31, 31, 1, 0)};
        vecs[10] = '{mk(8'h00, 0, 1, 0), ow(3, 7, 31, 0, 1, 0)};
        vecs[11] = '{mk(8'h00, 0, 0, 1), ow(4, 7, 31, 31, 1, 0)};
        vecs[12] = '{mk(8'hE9, 1, 0, 0), ow(5, 7, 9, 31, 1, 0)};
        vecs[13] = '{mk(8'h00, 0, 1, 1), ow(6, 7, 9, 9, 1, 0)};
        vecs[14] = '{mk(8'h00, 0, 0, 0), ow(7, 7, 9, 9, 1, 0)};
        vecs[15] = '{mk(8'h00, 0, 0, 0), ow(0, 7, 9, 9, 1, 1)};

        applyStimulus(mk(0, 0, 0, 0));
        bus2.data_in = '0;
        bus2.ld_ir   = 1'b0;
        bus2.inc_pc  = 1'b0;
        bus2.ld_pc   = 1'b0;
        bus2.halt    = 1'b0;
        bus2.go      = 1'b0;
        bus2.step    = 1'b0;
        rst_ = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_held", dut_word(), ow(0, 0, 0, 0, 1, 0));
        checkOutput("reset_held_halted_dut", dut2_word(), ow(0, 0, 0, 0, 0, 0));
        rst_ = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].s);
            @(negedge clk);
            checkOutput($sformatf("vector_%0d", i), dut_word(), vecs[i].exp);
        end

        // halt raised in phase 3: phases 4..7 still run, HALTED after the wrap.
        applyStimulus(mk(0, 0, 0, 0));
        repeat (3) @(negedge clk);
        checkValue("pre_halt_phase", int'(bus.phase), 3);
        s = mk(0, 0, 0, 0);
        s.halt = 1'b1;
        applyStimulus(s);
        @(negedge clk);
        applyStimulus(mk(0, 0, 0, 0));
        checkOutput("drain_phase4", dut_word(), ow(4, 7, 9, 9, 1, 0));
        for (int p = 5; p < 8; p++) begin
            @(negedge clk);
            checkOutput($sformatf("drain_phase%0d", p), dut_word(), ow(p, 7, 9, 9, 1, 0));
        end
        @(negedge clk);
        checkOutput("halted_entry", dut_word(), ow(0, 7, 9, 9, 0, 1));
        for (int i = 0; i < 20; i++) begin
            s = mk(int'($urandom_range(255)), 1, 1, 1);
            s.halt = 1'($urandom_range(1));
            applyStimulus(s);
            @(negedge clk);
            checkOutput("halted_ignores_strobes", dut_word(), ow(0, 7, 9, 9, 0, 0));
        end

        // Single step: exactly eight phases and one instr_done.
        s = mk(0, 0, 0, 0);
        s.step = 1'b1;
        applyStimulus(s);
        @(negedge clk);
        applyStimulus(mk(0, 0, 0, 0));
        checkOutput("step_start", dut_word(), ow(0, 7, 9, 9, 1, 0));
        cyc = 0; dones = 0; ended = 1'b0;
        for (int i = 1; i <= 20 && !ended; i++) begin
            @(negedge clk);
            if (bus.instr_done) dones++;
            if (!bus.running) begin
                ended = 1'b1;
                cyc = i;
            end
        end
        checkValue("step_cycles", cyc, 8);
        checkValue("step_done_pulses", dones, 1);
        checkOutput("step_end", dut_word(), ow(0, 7, 9, 9, 0, 1));
        repeat (3) @(negedge clk);
        checkOutput("step_stays_halted", dut_word(), ow(0, 7, 9, 9, 0, 0));

        // go and step together: go wins, machine keeps running.
        s = mk(0, 0, 0, 0);
        s.go = 1'b1;
        s.step = 1'b1;
        applyStimulus(s);
        @(negedge clk);
        applyStimulus(mk(0, 0, 0, 0));
        checkOutput("go_step_start", dut_word(), ow(0, 7, 9, 9, 1, 0));
        dones = 0; stayed = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.instr_done) dones++;
            if (bus.running !== 1'b1) stayed = 1'b0;
        end
        checkValue("go_wins_running", int'(stayed), 1);
        checkValue("go_wins_done_pulses", dones, 2);

        // Async reset in phase 5 of a loaded instruction.
        applyStimulus(mk(8'h5A, 1, 1, 0));
        @(negedge clk);
        applyStimulus(mk(0, 0, 0, 0));
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (bus.phase == 3'd5) found = 1'b1;
        end
        checkValue("reach_phase5", int'(found), 1);
        checkOutput("pre_reset", dut_word(), ow(5, 2, 26, 10, 1, 0));
        #2 rst_ = 1'b0;
        #1;
        checkOutput("async_reset", dut_word(), ow(0, 0, 0, 0, 1, 0));
        @(negedge clk);
        rst_ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("start_halted_idle", dut2_word(), ow(0, 0, 0, 0, 0, 0));
        end
        bus2.go = 1'b1;
        @(negedge clk);
        bus2.go = 1'b0;
        checkOutput("start_halted_go", dut2_word(), ow(0, 0, 0, 0, 1, 0));
        @(negedge clk);
        checkOutput("start_halted_runs", dut2_word(), ow(1, 0, 0, 0, 1, 0));

        // Random strobes and host commands against the model.
        for (int i = 0; i < 500; i++) begin
            s.data   = 8'($urandom);
            s.ld_ir  = ($urandom_range(3) == 0);
            s.inc_pc = ($urandom_range(2) == 0);
            s.ld_pc  = ($urandom_range(7) == 0);
            s.halt   = ($urandom_range(11) == 0);
            s.go     = ($urandom_range(9) == 0);
            s.step   = ($urandom_range(9) == 0);
            applyStimulus(s);
            @(negedge clk);
            checkOutput($sformatf("random_%0d", i), dut_word(), model_word());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
